// File: rtl/aaxi_pkg.sv
// aaxi_pkg: shared widths and arbiter state encoding for the aaxi bridge slice.
package aaxi_pkg;
  localparam int AAXI_AW = 30;
  localparam int AAXI_DW = 32;
  localparam int AAXI_SW = 4;
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t WAIT = 1'b1;
endpackage

// File: rtl/aaxi_rr_pick.sv
// aaxi_rr_pick: combinational round-robin pick, first request after last.
module aaxi_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  // Scanning farthest-first lets the nearest set bit overwrite earlier hits.
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        gnt = '0;
        gnt[(int'(last) + k) % N] = 1'b1;
        gnt_idx = IW'((int'(last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/aaxi_bridge_arbiter.sv
// aaxi_bridge_arbiter: shares the bridge slave side among N requesters, one transaction at a time.
// AAXI_ARB_PRIO_EN gives requester 0 absolute priority; others stay round robin.
module aaxi_bridge_arbiter
  import aaxi_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic                 s_clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         rq_avalid,
  output logic [N-1:0]         rq_aready,
  input  logic [N-1:0]         rq_awe,
  input  logic [N*AAXI_AW-1:0] rq_aaddr,
  input  logic [N*AAXI_DW-1:0] rq_adata,
  input  logic [N*AAXI_SW-1:0] rq_astrb,
  output logic [N-1:0]         rq_bvalid,
  output logic [AAXI_DW-1:0]   rq_bdata,
  output logic                 br_avalid,
  output logic                 br_awe,
  output logic [AAXI_AW-1:0]   br_aaddr,
  output logic [AAXI_DW-1:0]   br_adata,
  output logic [AAXI_SW-1:0]   br_astrb,
  input  logic                 br_bvalid,
  input  logic [AAXI_DW-1:0]   br_bdata,
  output logic [IW-1:0]        gnt_idx
);
  state_t state;
  logic [IW-1:0] last;
  logic [N-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;
  logic upd_last;
`ifdef AAXI_ARB_PRIO_EN
  logic [N-1:0] rr_gnt;
  logic [IW-1:0] rr_idx;
  aaxi_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req(rq_avalid & ~N'(1)), .last(last), .gnt(rr_gnt), .gnt_idx(rr_idx)
  );
  assign pick_gnt = rq_avalid[0] ? N'(1) : rr_gnt;
  assign pick_idx = rq_avalid[0] ? '0 : rr_idx;
  assign upd_last = gnt_idx != '0;
`else
  aaxi_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req(rq_avalid), .last(last), .gnt(pick_gnt), .gnt_idx(pick_idx)
  );
  assign upd_last = 1'b1;
`endif
  assign rq_aready = (rst_n && state == IDLE) ? pick_gnt : '0;
  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= IW'(N - 1);
      gnt_idx <= '0;
      rq_bvalid <= '0;
      rq_bdata <= '0;
      br_avalid <= 1'b0;
      br_awe <= 1'b0;
      br_aaddr <= '0;
      br_adata <= '0;
      br_astrb <= '0;
    end else begin
      rq_bvalid <= '0;
      br_avalid <= state == IDLE && |rq_avalid;
      if (state == IDLE && |rq_avalid) begin
        br_awe <= rq_awe[pick_idx];
        br_aaddr <= rq_aaddr[pick_idx*AAXI_AW +: AAXI_AW];
        br_adata <= rq_adata[pick_idx*AAXI_DW +: AAXI_DW];
        br_astrb <= rq_astrb[pick_idx*AAXI_SW +: AAXI_SW];
        gnt_idx <= pick_idx;
        state <= WAIT;
      end else if (state == WAIT && br_bvalid) begin
        rq_bvalid <= N'(1) << gnt_idx;
        rq_bdata <= br_bdata;
        last <= upd_last ? gnt_idx : last;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_aaxi_bridge_arbiter.sv
// tb_aaxi_bridge_arbiter: randomized arbiter bench with a bridge/memory model and transaction-level reference.
module tb_aaxi_bridge_arbiter;
  localparam int N = 4, IW = 2;
  logic s_clk = 1'b0, rst_n = 1'b0;
  always #5 s_clk = ~s_clk;
  logic [N-1:0] rq_avalid = '0, rq_awe = '0, rq_aready, rq_bvalid;
  logic [N*30-1:0] rq_aaddr;
  logic [N*32-1:0] rq_adata;
  logic [N*4-1:0] rq_astrb;
  logic [31:0] rq_bdata, br_adata, br_bdata;
  logic br_avalid, br_awe, br_bvalid;
  logic [29:0] br_aaddr;
  logic [3:0] br_astrb;
  logic [IW-1:0] gnt_idx;
  logic [29:0] a_addr[N];
  logic [31:0] a_data[N];
  logic [3:0] a_strb[N];
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign rq_aaddr[i*30 +: 30] = a_addr[i];
    assign rq_adata[i*32 +: 32] = a_data[i];
    assign rq_astrb[i*4 +: 4] = a_strb[i];
  end
  aaxi_bridge_arbiter #(.N(N), .IW(IW)) dut (
    .s_clk(s_clk), .rst_n(rst_n), .rq_avalid(rq_avalid), .rq_aready(rq_aready),
    .rq_awe(rq_awe), .rq_aaddr(rq_aaddr), .rq_adata(rq_adata), .rq_astrb(rq_astrb),
    .rq_bvalid(rq_bvalid), .rq_bdata(rq_bdata), .br_avalid(br_avalid), .br_awe(br_awe),
    .br_aaddr(br_aaddr), .br_adata(br_adata), .br_astrb(br_astrb), .br_bvalid(br_bvalid),
    .br_bdata(br_bdata), .gnt_idx(gnt_idx)
  );
  int checks = 0, errors = 0, overlap = 0, last_m = N - 1;
  logic inj = 1'b0;
  logic pend;
  int cnt;
  logic [29:0] baddr;
  logic [31:0] mem [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction
  // Bridge stand-in: accepts a pulse, answers once after 1..6 cycles.
  always @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      br_bvalid <= 1'b0;
      br_bdata <= '0;
    end else begin
      br_bvalid <= 1'b0;
      if (br_avalid) begin
        if (pend) overlap <= overlap + 1;
        pend <= 1'b1;
        cnt <= $urandom_range(1, 6);
        baddr <= br_aaddr;
        if (br_awe) mem[br_aaddr[7:0]] <= merge(mem[br_aaddr[7:0]], br_adata, br_astrb);
      end else if (pend) begin
        if (cnt == 1) begin
          pend <= 1'b0;
          br_bvalid <= 1'b1;
          br_bdata <= mem[baddr[7:0]];
        end else cnt <= cnt - 1;
      end
      if (inj) begin
        br_bvalid <= 1'b1;
        br_bdata <= 32'hDEAD_BEEF;
      end
    end
  end
  function automatic int pick(logic [N-1:0] r, int l);
`ifdef AAXI_ARB_PRIO_EN
    if (r[0]) return 0;
    r[0] = 1'b0;
`endif
    for (int k = 1; k <= N; k++) if (r[(l + k) % N]) return (l + k) % N;
    return -1;
  endfunction
  task automatic set_req(input int i, input logic w, input logic [29:0] ad, input logic [31:0] d, input logic [3:0] s);
    a_addr[i] = ad;
    a_data[i] = d;
    a_strb[i] = s;
    rq_awe[i] = w;
    rq_avalid[i] = 1'b1;
  endtask
  task automatic rnd_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), 30'($urandom_range(32, 255)), $urandom, 4'($urandom_range(1, 15)));
  endtask
  task automatic test_reset();
    rq_avalid = '0;
    rst_n = 1'b0;
    last_m = N - 1;
    repeat (2) @(negedge s_clk);
    checks++;
    if ({rq_aready, rq_bvalid, rq_bdata, br_avalid, br_awe, br_aaddr, br_adata, br_astrb, gnt_idx} !== '0)
      begin errors++; $display("FAIL reset_values aready=%b bvalid=%b avalid=%b gnt=%0d addr=%h", rq_aready, rq_bvalid, br_avalid, gnt_idx, br_aaddr); end
    rst_n = 1'b1;
    @(negedge s_clk);
  endtask
  // One complete transaction: grant, bridge pulse, response routing.
  task automatic do_txn(output int g);
    int ge, t;
    logic w;
    logic [29:0] ad;
    logic [31:0] d, ex;
    logic [3:0] s;
    g = -1;
    t = 0;
    #1;
    while (rq_aready == '0 && t < 20) begin @(negedge s_clk); t++; end
    ge = pick(rq_avalid, last_m);
    checks++;
    if (ge < 0 || rq_aready !== N'(1) << ge) begin
      errors++; $display("FAIL grant got=%b expected_idx=%0d req=%b", rq_aready, ge, rq_avalid);
      return;
    end
    g = ge;
    w = rq_awe[g]; ad = a_addr[g]; d = a_data[g]; s = a_strb[g];
    @(posedge s_clk);
    #1 rq_avalid[g] = 1'b0;
    @(negedge s_clk);
    checks++;
    if ({br_avalid, br_awe, br_aaddr, br_adata, br_astrb, gnt_idx} !== {1'b1, w, ad, d, s, IW'(g)})
      begin errors++; $display("FAIL forward got=%b/%b/%h/%h/%h/%0d need=1/%b/%h/%h/%h/%0d", br_avalid, br_awe, br_aaddr, br_adata, br_astrb, gnt_idx, w, ad, d, s, g); end
    if (w) ref_mem[ad[7:0]] = merge(ref_mem[ad[7:0]], d, s);
    ex = ref_mem[ad[7:0]];
    @(negedge s_clk);
    checks++;
    if ({br_avalid, rq_aready} !== '0)
      begin errors++; $display("FAIL wait_quiet avalid=%b aready=%b need 0", br_avalid, rq_aready); end
    t = 0;
    while (rq_bvalid == '0 && t < 20) begin @(negedge s_clk); t++; end
    checks++;
    if (rq_bvalid !== N'(1) << g) begin errors++; $display("FAIL response got=%b need=%b", rq_bvalid, N'(1) << g); end
    if (!w) begin
      checks++;
      if (rq_bdata !== ex) begin errors++; $display("FAIL read_data got=%h need=%h", rq_bdata, ex); end
    end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL overlap got=%0d need 0", overlap); end
`ifdef AAXI_ARB_PRIO_EN
    if (g != 0) last_m = g;
`else
    last_m = g;
`endif
  endtask
  task automatic test_single_write();
    int g;
    set_req(1, 1'b1, 30'h10, 32'h1234_5678, 4'hF);
    do_txn(g);
    checks++;
    if (g != 1 || mem[8'h10] !== 32'h1234_5678) begin errors++; $display("FAIL single_write g=%0d mem=%h need 1/12345678", g, mem[8'h10]); end
  endtask
  task automatic test_round_robin();
    int g;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    test_reset();
    for (int i = 0; i < N; i++) rnd_req(i);
    for (int k = 0; k < 6; k++) begin
      do_txn(g);
      checks++;
      if (g != order[k]) begin errors++; $display("FAIL rr_order step=%0d got=%0d need=%0d", k, g, order[k]); end
      if (k < 2 && g >= 0) rnd_req(g);
    end
  endtask
  task automatic test_back_to_back();
    int g;
    set_req(2, 1'b0, 30'h10, 32'h0, 4'h0);
    rnd_req(3);
    do_txn(g);
    checks++;
    if (g != 2 || rq_bdata !== 32'h1234_5678) begin errors++; $display("FAIL b2b_read g=%0d data=%h need 2/12345678", g, rq_bdata); end
    checks++;
    if (rq_aready !== 4'b1000) begin errors++; $display("FAIL b2b_turnaround aready=%b need 1000", rq_aready); end
    do_txn(g);
    checks++;
    if (g != 3) begin errors++; $display("FAIL b2b_second g=%0d need 3", g); end
  endtask
  task automatic test_spurious();
    int g;
    @(negedge s_clk);
    inj = 1'b1;
    @(negedge s_clk);
    inj = 1'b0;
    repeat (3) begin
      @(negedge s_clk);
      checks++;
      if (rq_bvalid !== '0) begin errors++; $display("FAIL spurious bvalid=%b need 0", rq_bvalid); end
    end
    rnd_req(0);
    do_txn(g);
    checks++;
    if (g != 0) begin errors++; $display("FAIL spurious_next g=%0d need 0", g); end
  endtask
  task automatic test_reset_mid();
    int g, t;
    set_req(1, 1'b1, 30'h11, 32'hA5A5_5A5A, 4'hF);
    t = 0;
    #1;
    while (rq_aready == '0 && t < 20) begin @(negedge s_clk); t++; end
    @(posedge s_clk);
    #1 rq_avalid[1] = 1'b0;
    rnd_req(3);
    @(negedge s_clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rq_aready, rq_bvalid, rq_bdata, br_avalid, br_awe, br_aaddr, br_adata, br_astrb, gnt_idx} !== '0)
      begin errors++; $display("FAIL reset_mid aready=%b avalid=%b awe=%b gnt=%0d addr=%h", rq_aready, br_avalid, br_awe, gnt_idx, br_aaddr); end
    last_m = N - 1;
    @(negedge s_clk);
    rst_n = 1'b1;
    set_req(1, 1'b1, 30'h11, 32'hA5A5_5A5A, 4'hF);
    do_txn(g);
    checks++;
    if (g != 1 || mem[8'h11] !== 32'hA5A5_5A5A) begin errors++; $display("FAIL retry g=%0d mem=%h need 1/a5a55a5a", g, mem[8'h11]); end
    do_txn(g);
    checks++;
    if (g != 3) begin errors++; $display("FAIL retry_drain g=%0d need 3", g); end
  endtask
  task automatic test_random();
    int g;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++)
        if (!rq_avalid[i] && $urandom_range(0, 2) == 0) rnd_req(i);
        else if (rq_avalid[i] && $urandom_range(0, 7) == 0) rq_avalid[i] = 1'b0;
      if (rq_avalid == '0) rnd_req($urandom_range(0, N - 1));
      do_txn(g);
    end
    for (int k = 0; k < N && rq_avalid != '0; k++) do_txn(g);
  endtask
`ifdef AAXI_ARB_PRIO_EN
  task automatic test_priority();
    int g;
    int order[5] = '{0, 0, 0, 1, 2};
    test_reset();
    rnd_req(0); rnd_req(1); rnd_req(2);
    for (int k = 0; k < 5; k++) begin
      do_txn(g);
      checks++;
      if (g != order[k]) begin errors++; $display("FAIL prio_order step=%0d got=%0d need=%0d", k, g, order[k]); end
      if (k < 2) rnd_req(0);
    end
  endtask
`endif
  initial begin
    for (int i = 0; i < N; i++) begin a_addr[i] = '0; a_data[i] = '0; a_strb[i] = '0; end
    test_reset();
    test_single_write();
    test_round_robin();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_random();
`ifdef AAXI_ARB_PRIO_EN
    test_priority();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
